// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader that fills instruction memory and gates the CPU
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [ADDR_WIDTH-2:0] NumWords,
   input  logic [7:0]            ByteIn,
   input  logic                  ByteValid,
   output logic                  ByteReady,
   output logic                  ImWrEn,
   output logic [ADDR_WIDTH-1:0] ImAddr,
   output logic [31:0]           ImData,
   output logic                  CpuHold,
   output logic                  Done,
   output logic                  Error
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RECV  = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int                  CAPACITY_INT = 2 ** (ADDR_WIDTH - 2);
   localparam logic [ADDR_WIDTH-2:0] CAPACITY   = CAPACITY_INT[ADDR_WIDTH-2:0];

   logic [2:0]            state;
   logic [ADDR_WIDTH-2:0] num_words;
   logic [ADDR_WIDTH-2:0] word_idx;
   logic [ADDR_WIDTH-2:0] word_idx_next;
   logic [1:0]            byte_idx;
   logic [7:0]            csum;
   logic [23:0]           shift;
   logic                  beat;

   // Handshake outputs decode the state register only, never ByteValid.
   assign ByteReady     = (state == S_RECV) || (state == S_CHECK);
   assign ImWrEn        = (state == S_WRITE);
   assign Done          = (state == S_DONE);
   assign CpuHold       = !(Done && !Error);
   assign beat          = ByteValid && ByteReady;
   assign word_idx_next = word_idx + 1'b1;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= S_IDLE;
         num_words <= '0;
         word_idx  <= '0;
         byte_idx  <= '0;
         csum      <= '0;
         shift     <= '0;
         ImAddr    <= '0;
         ImData    <= '0;
         Error     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  num_words <= NumWords;
                  word_idx  <= '0;
                  byte_idx  <= '0;
                  csum      <= '0;
                  if (NumWords > CAPACITY) begin
                     Error <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     Error <= 1'b0;
                     state <= (NumWords == '0) ? S_CHECK : S_RECV;
                  end
               end
            end
            S_RECV: begin
               if (beat) begin
                  csum     <= csum ^ ByteIn;
                  byte_idx <= byte_idx + 2'd1;
                  shift    <= {shift[15:0], ByteIn};
                  // Fourth byte completes the word; present it during WRITE.
                  if (byte_idx == 2'd3) begin
                     ImData <= {shift, ByteIn};
                     ImAddr <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
                     state  <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               word_idx <= word_idx_next;
               state    <= (word_idx_next == num_words) ? S_CHECK : S_RECV;
            end
            S_CHECK: begin
               if (beat) begin
                  Error <= (ByteIn != csum);
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
   localparam int AW = 8;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Start;
   logic [AW-2:0] NumWords;
   logic [7:0]    ByteIn;
   logic          ByteValid;
   logic          ByteReady;
   logic          ImWrEn;
   logic [AW-1:0] ImAddr;
   logic [31:0]   ImData;
   logic          CpuHold;
   logic          Done;
   logic          Error;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .NumWords(NumWords),
      .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
      .ImWrEn(ImWrEn), .ImAddr(ImAddr), .ImData(ImData),
      .CpuHold(CpuHold), .Done(Done), .Error(Error)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge Clock) cyc++;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            c;
   } wr_t;

   typedef struct {
      int         n;
      int         mode;
      bit         fixed;
      logic [7:0] cb;
      logic       exp_err;
      int         exp_wr;
   } vec_t;

   wr_t        wr_q[$];
   logic [7:0] data_q[$];
   logic [7:0] stream_q[$];
   bit         rdy_seen;
   logic [7:0] nominal [16] = '{8'h8C, 8'h03, 8'h00, 8'h00, 8'h8C, 8'h04, 8'h00, 8'h01,
                                8'h00, 8'h64, 8'h28, 8'h20, 8'h00, 8'hA4, 8'h30, 8'h22};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge Clock) begin
      if (ByteReady) rdy_seen = 1'b1;
      if (ImWrEn) begin
         wr_q.push_back('{ImAddr, ImData, cyc});
         chk("ready_in_write", {63'd0, ByteReady}, 64'd0);
      end
   end

   // Reference: data bytes, XOR checksum, then checksum byte (or an override).
   task automatic prep(input int n, input bit fixed, input logic [7:0] cb, input bit use_cb,
                       input bit corrupt);
      logic [7:0] x;
      x = 8'h00;
      data_q.delete();
      for (int i = 0; i < 4 * n; i++) begin
         data_q.push_back(fixed ? nominal[i % 16] : 8'($urandom));
         x = x ^ data_q[i];
      end
      stream_q = data_q;
      if (use_cb) stream_q.push_back(cb);
      else if (corrupt) stream_q.push_back(x ^ 8'($urandom_range(1, 255)));
      else stream_q.push_back(x);
   endtask

   task automatic start_load(input int n, output int t);
      Start = 1'b1;
      NumWords = n[AW-2:0];
      @(posedge Clock); #1;
      Start = 1'b0;
      t = cyc;
      chk("done_after_start", {63'd0, Done}, (n > 64) ? 64'd1 : 64'd0);
      chk("error_after_start", {63'd0, Error}, (n > 64) ? 64'd1 : 64'd0);
   endtask

   task automatic drive_stream(input int mode, input int budget, output int consumed);
      int  cnt;
      bit  v;
      bit  rdy;
      consumed = 0;
      cnt = 0;
      while (consumed < stream_q.size() && cnt < budget) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cnt % 3 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         ByteValid = v;
         ByteIn = v ? stream_q[consumed] : 8'($urandom);
         rdy = ByteReady;
         @(posedge Clock); #1;
         if (v && rdy) consumed++;
         cnt++;
      end
      ByteValid = 1'b0;
   endtask

   task automatic run_load(input int n, input int mode, input logic exp_err, input int exp_wr,
                           input string tag);
      int t;
      int got;
      int dc;
      logic [31:0] w;
      wr_q.delete();
      start_load(n, t);
      drive_stream(mode, 60 * n + 60, got);
      chk({tag, "_bytes"}, got, stream_q.size());
      for (int i = 0; i < 20 && !Done; i++) begin
         @(posedge Clock); #1;
      end
      dc = cyc;
      chk({tag, "_done"}, {63'd0, Done}, 64'd1);
      if (mode == 0) chk({tag, "_done_cycle"}, dc, t + 5 * n + 1);
      chk({tag, "_error"}, {63'd0, Error}, {63'd0, exp_err});
      chk({tag, "_hold"}, {63'd0, CpuHold}, {63'd0, exp_err});
      chk({tag, "_nwrites"}, wr_q.size(), exp_wr);
      for (int k = 0; k < wr_q.size() && k < n; k++) begin
         w = {data_q[4*k], data_q[4*k+1], data_q[4*k+2], data_q[4*k+3]};
         chk({tag, "_addr"}, wr_q[k].addr, 4 * k);
         chk({tag, "_data"}, wr_q[k].data, w);
         if (mode == 0) chk({tag, "_wr_cycle"}, wr_q[k].c, t + 4 + 5 * k);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vecs[5];
      int   t;
      int   got;
      int   n;
      bit   corrupt;

      vecs[0] = '{n: 4, mode: 0, fixed: 1, cb: 8'hDC, exp_err: 1'b0, exp_wr: 4};
      vecs[1] = '{n: 4, mode: 0, fixed: 1, cb: 8'hDD, exp_err: 1'b1, exp_wr: 4};
      vecs[2] = '{n: 4, mode: 1, fixed: 1, cb: 8'hDC, exp_err: 1'b0, exp_wr: 4};
      vecs[3] = '{n: 0, mode: 0, fixed: 0, cb: 8'h00, exp_err: 1'b0, exp_wr: 0};
      vecs[4] = '{n: 0, mode: 0, fixed: 0, cb: 8'h01, exp_err: 1'b1, exp_wr: 0};

      Reset = 1'b1; Start = 1'b0; NumWords = '0; ByteIn = '0; ByteValid = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b0;
      chk("rst_ready", {63'd0, ByteReady}, 64'd0);
      chk("rst_wren", {63'd0, ImWrEn}, 64'd0);
      chk("rst_done", {63'd0, Done}, 64'd0);
      chk("rst_error", {63'd0, Error}, 64'd0);
      chk("rst_addr", ImAddr, 64'd0);
      chk("rst_data", ImData, 64'd0);
      chk("rst_hold", {63'd0, CpuHold}, 64'd1);

      for (int i = 0; i < 5; i++) begin
         prep(vecs[i].n, vecs[i].fixed, vecs[i].cb, 1'b1, 1'b0);
         run_load(vecs[i].n, vecs[i].mode, vecs[i].exp_err, vecs[i].exp_wr, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 6; i++) begin
         n = $urandom_range(1, 8);
         corrupt = 1'($urandom_range(0, 1));
         prep(n, 1'b0, 8'h00, 1'b0, corrupt);
         run_load(n, $urandom_range(0, 2), corrupt, n, $sformatf("rand%0d", i));
      end

      prep(64, 1'b0, 8'h00, 1'b0, 1'b0);
      run_load(64, 0, 1'b0, 64, "capacity");
      if (wr_q.size() == 64) chk("capacity_last_addr", wr_q[63].addr, 64'd252);

      wr_q.delete();
      rdy_seen = 1'b0;
      start_load(65, t);
      @(posedge Clock); #1;
      chk("over_done", {63'd0, Done}, 64'd1);
      chk("over_error", {63'd0, Error}, 64'd1);
      chk("over_hold", {63'd0, CpuHold}, 64'd1);
      chk("over_ready_seen", {63'd0, rdy_seen}, 64'd0);
      chk("over_nwrites", wr_q.size(), 64'd0);

      prep(4, 1'b1, 8'hDC, 1'b1, 1'b0);
      while (stream_q.size() > 6) void'(stream_q.pop_back());
      wr_q.delete();
      start_load(4, t);
      drive_stream(0, 50, got);
      chk("midrst_bytes", got, 64'd6);
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      chk("midrst_ready", {63'd0, ByteReady}, 64'd0);
      chk("midrst_wren", {63'd0, ImWrEn}, 64'd0);
      chk("midrst_done", {63'd0, Done}, 64'd0);
      chk("midrst_error", {63'd0, Error}, 64'd0);
      chk("midrst_addr", ImAddr, 64'd0);
      chk("midrst_data", ImData, 64'd0);
      chk("midrst_hold", {63'd0, CpuHold}, 64'd1);
      repeat (3) @(posedge Clock);
      #1;
      chk("midrst_nwrites", wr_q.size(), 64'd1);
      if (wr_q.size() >= 1) begin
         chk("midrst_w0_addr", wr_q[0].addr, 64'd0);
         chk("midrst_w0_data", wr_q[0].data, 64'h8C030000);
      end
      prep(4, 1'b1, 8'hDC, 1'b1, 1'b0);
      run_load(4, 0, 1'b0, 4, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the pipelined CPU. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into instruction memory at byte addresses 0, 4, 8, …. It verifies a trailing XOR checksum, and holds the CPU stalled until a load completes cleanly. It is the hardware write side of the instruction-memory port that the fetch stage reads.

## Interface

Parameters:
- ADDR_WIDTH, 8, byte-address width of instruction memory. Capacity is 2^(ADDR_WIDTH-2) words.

Ports:
- Clock  input  1  system clock; all logic is rising-edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  level; sampled in IDLE and DONE to begin a load.
- NumWords  input  ADDR_WIDTH-1  number of words to load; latched on the accepted Start.
- ByteIn  input  8  stream data.
- ByteValid  input  1  ByteIn is valid.
- ByteReady  output  1  loader accepts ByteIn this cycle.
- ImWrEn  output  1  instruction-memory write strobe.
- ImAddr  output  ADDR_WIDTH  byte address; always a multiple of 4.
- ImData  output  32  write data.
- CpuHold  output  1  stalls the CPU (PC and pipeline) while 1.
- Done  output  1  load finished; checksum evaluated.
- Error  output  1  checksum mismatch or oversize NumWords.

## Operation

- Reset values:
  - State is IDLE.
  - ByteReady, ImWrEn, Done and Error are 0.
  - ImAddr and ImData are 0.
  - CpuHold is 1.
  - Internal byte index, word index and checksum are 0.
- A "beat" is a cycle with ByteValid=1 and ByteReady=1. Only beats advance the state.
- States:
  - IDLE
    - ByteReady=0.
    - On Start=1: latch NumWords and clear the checksum, word index and byte index.
    - If NumWords > 2^(ADDR_WIDTH-2): set Error=1 and go to DONE.
    - Else if NumWords == 0: go to CHECK.
    - Else: go to RECV.
  - RECV
    - ByteReady=1.
    - Each beat shifts ByteIn into the word, first byte into [31:24], and XORs it into the checksum.
    - On the 4th beat, go to WRITE.
  - WRITE (one cycle)
    - ByteReady=0, ImWrEn=1, ImAddr = word index × 4, ImData = the assembled word.
    - Increment the word index.
    - If the new index equals NumWords, go to CHECK; else go to RECV.
  - CHECK
    - ByteReady=1.
    - On one beat: Error = (ByteIn != running checksum). Go to DONE.
  - DONE
    - Done=1, ByteReady=0, CpuHold=Error.
    - Start=1 restarts exactly as from IDLE: clears Done and Error the next cycle.
- CpuHold is 1 in every state except DONE with Error=0.
- ImData and ImAddr hold their last values outside WRITE. Memory must qualify them with ImWrEn.
- Word-index arithmetic is ADDR_WIDTH-1 bits wide, so NumWords equal to exactly capacity is legal. The final write lands at address (2^(ADDR_WIDTH-2) - 1) × 4, with no wrap.
- The checksum covers data bytes only. The checksum byte itself is excluded.
- Reset at any point returns to reset values next cycle:
  - A partially assembled word is discarded and never written.
  - Writes already performed are not undone.

## Timing

- A Start accepted at cycle t gives state RECV (or CHECK) at t+1.
- With ByteValid held at 1:
  - Each word takes 4 beat cycles plus 1 WRITE cycle.
  - ImWrEn for word k pulses at t+5k+5 (k from 0).
  - The checksum beat falls at t+5N+1, and Done=1 at t+5N+2.
- Back-pressure: ByteValid=0 cycles stall in place with no state change. ByteIn is ignored when ByteValid=0 or ByteReady=0.
- ByteReady is a registered state decode and has no combinational dependence on ByteValid.
- Start=1 outside IDLE and DONE is ignored.
- Start held high in DONE restarts every time DONE is entered. Start must be a pulse or be deasserted upon Done.
- Reset wins over Start and over beats in the same cycle.

## Test plan

- Nominal load:
  - Stimulus: NumWords=4; stream 8C 03 00 00 8C 04 00 01 00 64 28 20 00 A4 30 22, then DC, with ByteValid held high.
  - Required: writes 8C030000@0, 8C040001@4, 00642820@8, 00A43022@12, exactly 4 ImWrEn pulses spaced 5 cycles apart, Done=1, Error=0, CpuHold=0.
- Bad checksum:
  - Stimulus: same stream with final byte DD.
  - Required: 4 writes occur, Done=1, Error=1, CpuHold=1.
- Back-pressure:
  - Stimulus: nominal stream with ByteValid toggling 1,0,0,1,….
  - Required: same writes and data as nominal, no extra beats, ByteReady=0 in each WRITE cycle.
- Empty load:
  - Stimulus: NumWords=0, single byte 00.
  - Required: no ImWrEn, Done=1, Error=0. Repeating with byte 01 gives Error=1.
- Oversize (ADDR_WIDTH=8):
  - Stimulus: NumWords=65.
  - Required: Done=1, Error=1 two cycles after Start, ByteReady never asserted, no writes.
  - NumWords=64 must write through address 252.
- Reset mid-word:
  - Stimulus: Reset asserted after 2 beats of word 1 in the nominal load.
  - Required: all outputs return to reset values, only the 8C030000@0 write occurred, and a subsequent full nominal load succeeds.
